// File: rtl/div_seq_4b.sv
// Sequential restoring divider: one quotient bit per cycle.
// Divide-by-zero short-circuits straight to DONE with a flag.
module div_seq_4b #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t           state;
  logic [WIDTH:0]   rem_q;
  logic [WIDTH-1:0] quo_q;
  logic [WIDTH-1:0] dvs_q;
  logic [CW-1:0]    cnt;

  logic [WIDTH:0]   r_sh;
  logic [WIDTH:0]   trial;
  logic [WIDTH:0]   r_nxt;
  logic [WIDTH-1:0] q_nxt;
  logic             borrow;

  // Trial subtract as add of the one's complement plus one.
  always_comb begin
    r_sh   = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    trial  = r_sh + ~{1'b0, dvs_q}
           + {{WIDTH{1'b0}}, 1'b1};
    borrow = trial[WIDTH];
    r_nxt  = borrow ? r_sh : trial;
    q_nxt  = {quo_q[WIDTH-2:0], ~borrow};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      cnt         <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE, DONE: begin
          if (start) begin
            dvs_q <= divisor;
            rem_q <= '0;
            quo_q <= dividend;
            cnt   <= CW'(WIDTH);
            if (divisor == '0) begin
              state       <= DONE;
              busy        <= 1'b0;
              done        <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend;
              div_by_zero <= 1'b1;
            end else begin
              state <= CALC;
              busy  <= 1'b1;
            end
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        CALC: begin
          rem_q <= r_nxt;
          quo_q <= q_nxt;
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state       <= DONE;
            busy        <= 1'b0;
            done        <= 1'b1;
            quotient    <= q_nxt;
            remainder   <= r_nxt[WIDTH-1:0];
            div_by_zero <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_div_seq_4b.sv
// Bench for div_seq_4b: directed cases plus random
// operands checked against plain integer division.
module tb_div_seq_4b;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] dividend = '0;
  logic [3:0] divisor = '0;
  logic       busy;
  logic       done;
  logic [3:0] quotient;
  logic [3:0] remainder;
  logic       div_by_zero;

  int checks = 0;
  int errors = 0;

  logic [3:0] exp_q = '0;
  logic [3:0] exp_r = '0;
  logic       exp_z = 1'b0;

  always #5 clk = ~clk;

  div_seq_4b #(.WIDTH(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .dividend   (dividend),
    .divisor    (divisor),
    .busy       (busy),
    .done       (done),
    .quotient   (quotient),
    .remainder  (remainder),
    .div_by_zero(div_by_zero)
  );

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d",
             tag, obs, exp);
    end
  endtask

  task automatic model(input logic [3:0] a,
                       input logic [3:0] b);
    if (b == 0) begin
      exp_q = 4'd15;
      exp_r = a;
      exp_z = 1'b1;
    end else begin
      exp_q = 4'(int'(a) / int'(b));
      exp_r = 4'(int'(a) % int'(b));
      exp_z = 1'b0;
    end
  endtask

  // Called just after the accepting edge; returns at the
  // negedge of the done cycle (lat = cycle index, 1-based).
  task automatic wait_done(input int pulse_cyc,
                           output int lat,
                           output int nbusy,
                           output bit seen);
    lat = 0;
    nbusy = 0;
    seen = 0;
    while (!seen && lat < 20) begin
      @(negedge clk);
      lat++;
      if (done) begin
        seen = 1;
      end else begin
        if (busy) nbusy++;
        chk("hold_q", quotient, exp_q);
        chk("hold_r", remainder, exp_r);
        chk("hold_z", div_by_zero, exp_z);
      end
      if (pulse_cyc != 0 && lat == pulse_cyc) begin
        start = 1'b1;
        dividend = 4'd6;
        divisor = 4'd2;
      end else if (pulse_cyc != 0 && lat == pulse_cyc + 1) begin
        start = 1'b0;
      end
    end
    chk("done_seen", seen, 1);
  endtask

  task automatic check_results(input string tag);
    chk({tag, "_q"}, quotient, exp_q);
    chk({tag, "_r"}, remainder, exp_r);
    chk({tag, "_z"}, div_by_zero, exp_z);
    chk({tag, "_busy_at_done"}, busy, 0);
  endtask

  task automatic run_op(input logic [3:0] a,
                        input logic [3:0] b,
                        input int pulse_cyc);
    int lat, nb;
    bit seen;
    @(negedge clk);
    start = 1'b1;
    dividend = a;
    divisor = b;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = 4'($urandom);
    divisor = 4'($urandom);
    wait_done(pulse_cyc, lat, nb, seen);
    model(a, b);
    chk("latency", lat, (b == 0) ? 1 : 5);
    chk("busy_cycles", nb, (b == 0) ? 0 : 4);
    check_results("op");
    @(negedge clk);
    chk("done_pulse_end", done, 0);
  endtask

  initial begin
    int lat, nb, lat2;
    bit seen;

    #12;
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_z", div_by_zero, 0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(4'd13, 4'd4, 0);
    chk("13_4_q", exp_q, 3);
    run_op(4'd15, 4'd1, 0);
    run_op(4'd3, 4'd7, 0);
    run_op(4'd0, 4'd5, 0);
    run_op(4'd9, 4'd0, 0);

    // Second start pulsed in CALC must be ignored.
    run_op(4'd14, 4'd3, 2);
    chk("ign_q", quotient, 4);
    chk("ign_r", remainder, 2);

    // Start held high through DONE: back-to-back ops.
    @(negedge clk);
    start = 1'b1;
    dividend = 4'd12;
    divisor = 4'd5;
    @(posedge clk);
    #1;
    dividend = 4'd8;
    divisor = 4'd3;
    wait_done(0, lat, nb, seen);
    model(4'd12, 4'd5);
    chk("b2b_lat1", lat, 5);
    check_results("b2b1");
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_done(0, lat2, nb, seen);
    model(4'd8, 4'd3);
    chk("b2b_spacing", lat2 + 1, 6);
    check_results("b2b2");

    // Reset in the 2nd CALC cycle aborts with no done.
    @(negedge clk);
    start = 1'b1;
    dividend = 4'd11;
    divisor = 4'd2;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    exp_q = '0;
    exp_r = '0;
    exp_z = 1'b0;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", done, 0);
    chk("mid_rst_q", quotient, 0);
    chk("mid_rst_r", remainder, 0);
    chk("mid_rst_z", div_by_zero, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    run_op(4'd11, 4'd2, 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("idle_no_done", done, 0);
    end

    for (int i = 0; i < 40; i++) begin
      run_op(4'($urandom), 4'($urandom_range(0, 15)), 0);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
